// File: rtl/apb_cmd_master.sv
// APB initiator: turns a valid/ready command stream into APB SETUP/ACCESS transfers
// and returns read data or a timeout flag on a valid/ready response channel.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no transfer in flight, cmd_ready=1
// SETUP  | psel=1, penable=0 for one cycle, wait counter cleared
// ACCESS | psel=1, penable=1, waiting for pready or timeout
// RESP   | rsp_valid=1 held until rsp_ready; may accept the next command
module apb_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          accept;
    logic          timeout_hit;

    // In RESP the next command can ride the same edge that retires the response.
    assign cmd_ready   = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept      = cmd_valid && cmd_ready;
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pwrite <= cmd_write;
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // pready is checked first so it wins over a same-cycle timeout.
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (cmd_valid) begin
                            pwrite <= cmd_write;
                            paddr  <= cmd_addr;
                            pwdata <= cmd_wdata;
                            psel   <= 1'b1;
                            state  <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
